// File: rtl/alu_serial_sequencer.sv
// Bit-serial sequencer: drives a single 1-bit ALU slice LSB-first across a WIDTH-bit
// operation, rippling the carry through a register and assembling the result.
module alu_serial_sequencer #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zero,
    output logic             alu_a,
    output logic             alu_b,
    output logic             alu_carry_in,
    output logic [3:0]       alu_op,
    input  logic             alu_result,
    input  logic             alu_carry_out
);

    localparam int unsigned CNT_W  = $clog2(WIDTH);
    localparam logic [3:0]  OP_SUB = 4'b0110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   sh_a_q, sh_a_d;
    logic [WIDTH-1:0]   sh_b_q, sh_b_d;
    logic [WIDTH-1:0]   res_sh_q, res_sh_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [WIDTH-1:0]   res_next;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         op_q, op_d;
    logic               carry_q, carry_d;
    logic               carry_out_q, carry_out_d;
    logic               zero_q, zero_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               accept;
    logic               last_bit;

    assign accept   = start && (state_q != S_RUN);
    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));
    assign res_next = {alu_result, res_sh_q[WIDTH-1:1]};

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (last_bit) state_d = S_DONE;
            S_DONE:  state_d = start ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and output next values; operand shifters drain to zero so the
    // slice inputs read as zero outside RUN without extra gating.
    always_comb begin
        sh_a_d      = sh_a_q;
        sh_b_d      = sh_b_q;
        res_sh_d    = res_sh_q;
        result_d    = result_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        carry_d     = carry_q;
        carry_out_d = carry_out_q;
        zero_d      = zero_q;
        busy_d      = (state_d == S_RUN);
        done_d      = (state_d == S_DONE);
        if (accept) begin
            sh_a_d   = opa;
            sh_b_d   = opb;
            op_d     = op;
            cnt_d    = '0;
            carry_d  = (op == OP_SUB);
            res_sh_d = '0;
        end else if (state_q == S_RUN) begin
            sh_a_d   = {1'b0, sh_a_q[WIDTH-1:1]};
            sh_b_d   = {1'b0, sh_b_q[WIDTH-1:1]};
            res_sh_d = res_next;
            carry_d  = alu_carry_out;
            cnt_d    = cnt_q + CNT_W'(1);
            if (last_bit) begin
                result_d    = res_next;
                zero_d      = (res_next == '0);
                carry_out_d = alu_carry_out;
                carry_d     = 1'b0;
                op_d        = 4'b0000;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sh_a_q      <= '0;
            sh_b_q      <= '0;
            res_sh_q    <= '0;
            result_q    <= '0;
            cnt_q       <= '0;
            op_q        <= 4'b0000;
            carry_q     <= 1'b0;
            carry_out_q <= 1'b0;
            zero_q      <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            sh_a_q      <= sh_a_d;
            sh_b_q      <= sh_b_d;
            res_sh_q    <= res_sh_d;
            result_q    <= result_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            carry_q     <= carry_d;
            carry_out_q <= carry_out_d;
            zero_q      <= zero_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign result       = result_q;
    assign carry_out    = carry_out_q;
    assign zero         = zero_q;
    assign alu_a        = sh_a_q[0];
    assign alu_b        = sh_b_q[0];
    assign alu_carry_in = carry_q;
    assign alu_op       = op_q;

endmodule

// File: tb/tb_alu_serial_sequencer.sv
// Bench for alu_serial_sequencer: behavioural 1-bit slice plus a full-width
// arithmetic reference model, directed and random operations.
module tb_alu_serial_sequencer;

    localparam int unsigned W = 64;
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;

    logic         clk = 1'b0;
    logic         reset, start;
    logic [3:0]   op;
    logic [W-1:0] opa, opb;
    logic         busy, done, carry_out, zero;
    logic [W-1:0] result;
    logic         alu_a, alu_b, alu_carry_in;
    logic [3:0]   alu_op;
    logic         alu_result, alu_carry_out;
    logic         bb;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    alu_serial_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .opa(opa), .opb(opb),
        .busy(busy), .done(done), .result(result), .carry_out(carry_out), .zero(zero),
        .alu_a(alu_a), .alu_b(alu_b), .alu_carry_in(alu_carry_in), .alu_op(alu_op),
        .alu_result(alu_result), .alu_carry_out(alu_carry_out)
    );

    // 1-bit ALU slice: Binvert is ALUOp[2], function select is ALUOp[1:0]
    always_comb begin
        bb = alu_b ^ alu_op[2];
        case (alu_op[1:0])
            2'b00:   alu_result = alu_a & bb;
            2'b01:   alu_result = alu_a | bb;
            2'b10:   alu_result = alu_a ^ bb ^ alu_carry_in;
            default: alu_result = 1'b0;
        endcase
        alu_carry_out = (alu_a & bb) | (alu_a & alu_carry_in) | (bb & alu_carry_in);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: whole-word arithmetic; the carry chain runs for every op
    function automatic void model(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic c, output logic z);
        logic [W:0] full;
        full = {1'b0, a} + {1'b0, (o[2] ? ~b : b)} + (W+1)'(o == OP_SUB);
        case (o)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            default: r = full[W-1:0];
        endcase
        c = full[W];
        z = (r == '0);
    endfunction

    // Called at a negedge; returns at the negedge of the first RUN cycle
    task automatic launch(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        op = o; opa = a; opb = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Follows one operation from its first RUN cycle to its done cycle
    task automatic wait_done(input string tag, input logic [3:0] o, input logic [W-1:0] a,
                             input logic [W-1:0] b, input int pulse_at);
        logic [W-1:0] er;
        logic ec, ez, seen, op_bad;
        int cyc, busy_n;
        model(o, a, b, er, ec, ez);
        busy_n = 0; op_bad = 1'b0; seen = 1'b0;
        chk({tag, "_cin_first"}, 64'(alu_carry_in), 64'(o == OP_SUB));
        for (cyc = 1; cyc <= int'(W) + 20; cyc++) begin
            if (pulse_at > 0) begin
                start = (cyc == pulse_at);
                opa   = ~a;
            end
            if (busy) begin
                busy_n++;
                if (alu_op !== o) op_bad = 1'b1;
            end
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk({tag, "_done_seen"}, 64'(seen), 64'(1));
        chk({tag, "_latency"}, 64'(cyc), 64'(W + 1));
        chk({tag, "_busy_cycles"}, 64'(busy_n), 64'(W));
        chk({tag, "_alu_op_run"}, 64'(op_bad), 64'(0));
        chk({tag, "_result"}, result, er);
        chk({tag, "_carry"}, 64'(carry_out), 64'(ec));
        chk({tag, "_zero"}, 64'(zero), 64'(ez));
    endtask

    task automatic idle_after(input string tag, input logic [W-1:0] er);
        @(negedge clk);
        chk({tag, "_done_drop"}, 64'(done), 64'(0));
        chk({tag, "_busy_idle"}, 64'(busy), 64'(0));
        chk({tag, "_op_idle"}, 64'(alu_op), 64'(0));
        chk({tag, "_held"}, result, er);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] ops [4];
        logic [3:0] o;
        logic [W-1:0] a, b, er;
        logic ec, ez;
        int dn;
        ops[0] = OP_AND; ops[1] = OP_OR; ops[2] = OP_ADD; ops[3] = OP_SUB;

        reset = 1'b1; start = 1'b0; op = 4'b0; opa = '0; opb = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_result", result, 64'(0));
        chk("rst_carry", 64'(carry_out), 64'(0));
        chk("rst_zero", 64'(zero), 64'(1));
        chk("rst_slice", 64'({alu_a, alu_b, alu_carry_in, alu_op}), 64'(0));
        reset = 1'b0;
        @(negedge clk);

        launch(OP_ADD, 64'd5, 64'd3);
        wait_done("add5_3", OP_ADD, 64'd5, 64'd3, 0);
        chk("add5_3_const", result, 64'd8);
        idle_after("add5_3", 64'd8);

        launch(OP_ADD, '1, 64'd1);
        wait_done("add_ovf", OP_ADD, '1, 64'd1, 0);
        chk("add_ovf_const", 64'({carry_out, zero}), 64'(2'b11));
        @(negedge clk);

        launch(OP_SUB, 64'd3, 64'd5);
        wait_done("sub3_5", OP_SUB, 64'd3, 64'd5, 0);
        chk("sub3_5_const", result, 64'hFFFF_FFFF_FFFF_FFFE);
        @(negedge clk);

        launch(OP_SUB, 64'd5, 64'd5);
        wait_done("sub5_5", OP_SUB, 64'd5, 64'd5, 0);
        @(negedge clk);

        launch(OP_AND, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00);
        wait_done("and", OP_AND, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 0);
        chk("and_const", result, 64'hF000_F000_F000_F000);
        @(negedge clk);

        launch(OP_OR, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00);
        wait_done("or", OP_OR, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 0);
        chk("or_const", result, 64'hFFF0_FFF0_FFF0_FFF0);
        @(negedge clk);

        // start mid-RUN must be ignored
        launch(OP_ADD, 64'd100, 64'd23);
        wait_done("midstart", OP_ADD, 64'd100, 64'd23, 10);
        idle_after("midstart", 64'd123);

        // reset at RUN bit 20 discards the operation
        launch(OP_ADD, 64'h1234, 64'h4321);
        repeat (20) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rstrun_busy", 64'(busy), 64'(0));
        chk("rstrun_result", result, 64'(0));
        chk("rstrun_zero", 64'(zero), 64'(1));
        chk("rstrun_slice", 64'({alu_a, alu_b, alu_carry_in, alu_op}), 64'(0));
        dn = 0;
        repeat (70) begin
            if (done) dn++;
            @(negedge clk);
        end
        chk("rstrun_no_done", 64'(dn), 64'(0));

        launch(OP_ADD, 64'd7, 64'd9);
        wait_done("add7_9", OP_ADD, 64'd7, 64'd9, 0);
        chk("add7_9_const", result, 64'd16);
        @(negedge clk);

        // reset and start together: reset wins
        reset = 1'b1; start = 1'b1; op = OP_ADD;
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("rst_start_busy", 64'(busy), 64'(0));

        // back-to-back: second start held in the DONE cycle
        launch(OP_SUB, 64'd1000, 64'd1);
        wait_done("b2b_1", OP_SUB, 64'd1000, 64'd1, 0);
        launch(OP_ADD, 64'hDEAD_BEEF, 64'h1111_1111);
        wait_done("b2b_2", OP_ADD, 64'hDEAD_BEEF, 64'h1111_1111, 0);
        @(negedge clk);

        // random operations, sometimes chained back-to-back
        for (int i = 0; i < 10; i++) begin
            o = ops[$urandom_range(0, 3)];
            a = {$urandom, $urandom};
            b = (i == 3) ? a : {$urandom, $urandom};
            launch(o, a, b);
            wait_done("rand", o, a, b, 0);
            model(o, a, b, er, ec, ez);
            if ($urandom_range(0, 1) == 0) idle_after("rand", er);
        end
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
